// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice per cycle, LSB first.
// Results and flags are held from one completed operation until the next completes.
module serial_add_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             last_c;
    logic             sum_c;
    logic             cout_c;
    logic [WIDTH-1:0] res_c;

    // Single full-adder slice on the current LSBs; partial sum fills from the MSB side
    always_comb begin
        sum_c  = a_q[0] ^ b_q[0] ^ carry_q;
        cout_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        res_c  = {sum_c, sum_q};
        last_c = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= op_a;
                        b_q     <= op_b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= res_c[WIDTH-1:1];
                    carry_q <= cout_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_c) begin
                        result    <= res_c;
                        zero      <= (res_c == '0);
                        carry_out <= cout_c;
                        overflow  <= carry_q ^ cout_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=32): directed table, corner sequences, random ops.
module tb_serial_add_sub;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] last_res = '0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic: plain integer add/subtract with signed overflow rule
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic co, output logic ov, output logic z);
        logic [W:0] full;
        if (s) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   full = {1'b0, a} + {1'b0, b};
        r  = full[W-1:0];
        co = full[W];
        if (s) ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        else   ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        z  = (r == '0);
    endtask

    // Issue one op, check latency, hold/stall behaviour and final result/flags
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int stall, input logic [W-1:0] er, input logic eco,
                         input logic eov, input logic ez);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick;
            n++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'(1));
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        out_ready = 1'(($urandom_range(0, 1)));
        tick;
        n = 1;
        // post-accept input changes and in_valid must be ignored
        op_a = $urandom; op_b = $urandom; sub = 1'($urandom_range(0, 1));
        check("in_ready_low_in_run", 64'(in_ready), 64'(0));
        while (!out_valid && n < 100) begin
            if (n == 16) check("result_held_in_run", 64'(result), 64'(last_res));
            tick;
            n++;
        end
        check("latency", 64'(n), 64'(W + 1));
        check("result", 64'(result), 64'(er));
        check("carry_out", 64'(carry_out), 64'(eco));
        check("overflow", 64'(overflow), 64'(eov));
        check("zero", 64'(zero), 64'(ez));
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            op_a = $urandom; op_b = $urandom;
            tick;
            check("stall_hold", 64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, er}));
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick;
        check("release_to_idle", 64'({out_valid, in_ready, result, carry_out, overflow, zero}),
              64'({1'b0, 1'b1, er, eco, eov, ez}));
        out_ready = 1'b0;
        last_res  = er;
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic [W-1:0] er;
        logic         eco;
        logic         eov;
        logic         ez;
        int           n;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0;
        tick;
        tick;
        check("reset_state", 64'({in_ready, out_valid, result, carry_out, overflow, zero}),
              64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}));
        rst = 1'b0;
        tick;

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, (i == 0) ? 10 : 1,
                  vecs[i].r, vecs[i].co, vecs[i].ov, vecs[i].z);

        // Reset in the middle of RUN aborts the op, then 1+1 runs normally
        op_a = 32'h1234_5678; op_b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_reset", 64'({in_ready, out_valid, result, zero}),
              64'({1'b1, 1'b0, 32'h0, 1'b1}));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (out_valid) n++;
        end
        check("no_valid_after_abort", 64'(n), 64'(0));
        last_res = '0;
        do_op(32'h1, 32'h1, 1'b0, 0, 32'h2, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0:       begin ra = 32'h8000_0000; rb = $urandom; end
                1:       begin ra = $urandom; rb = 32'h7FFF_FFFF; end
                2:       begin ra = $urandom; rb = ra; end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, er, eco, eov, ez);
            do_op(ra, rb, rs, $urandom_range(0, 3), er, eco, eov, ez);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
